return_addr_stack: RTL and testbench

Circular return-address stack (RAS) for the fetch stage. It takes the link value produced by the PC+4 adder and replays it later. When a call (JAL/JALR with rd = x1 or x5) executes, the sequential address `PCPlus4` is pushed. When a return executes, the top entry is popped and presented as the predicted return target to the next-PC mux. The block holds all state for call/return pairing; the processor core only drives strobes.

---
 rtl/return_addr_stack.sv | 76 +++++++
 tb/tb_return_addr_stack.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack that pushes the link address on calls and pops the predicted target on returns.
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [AW-1:0]              PCPlus4,
    output logic [AW-1:0]              RetAddr,
    output logic                       RetValid,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Overflow,
    output logic                       Underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, wr_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, wr;
    logic          empty, full;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(DEPTH);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        wr     = 1'b0;
        wr_idx = ptr_q;
        if (flush) begin
            cnt_d = '0;
        end else if (push && pop && !empty) begin
            wr = 1'b1;
        end else if (push) begin
            // a push onto a full stack wraps over the oldest entry and keeps the count saturated
            ptr_d  = ptr_q + 1'b1;
            wr_idx = ptr_q + 1'b1;
            wr     = 1'b1;
            cnt_d  = full ? cnt_q : cnt_q + 1'b1;
            ovf_d  = full;
        end else if (pop) begin
            unf_d = empty;
            ptr_d = empty ? ptr_q : ptr_q - 1'b1;
            cnt_d = empty ? cnt_q : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr) mem_q[wr_idx] <= PCPlus4;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign RetAddr   = empty ? '0 : mem_q[ptr_q];
    assign RetValid  = !empty;
    assign Count     = cnt_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: directed and randomized checks of return_addr_stack against a bounded queue model.
module tb_return_addr_stack;
    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic [AW-1:0] PCPlus4 = '0;
    logic [AW-1:0] RetAddr;
    logic          RetValid, Overflow, Underflow;
    logic [CW-1:0] Count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [AW-1:0] q[$];
    bit            e_ovf, e_unf;

    return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
        .PCPlus4(PCPlus4), .RetAddr(RetAddr), .RetValid(RetValid),
        .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a bounded LIFO; the newest entry is q[$], the oldest falls off the front.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            e_ovf = 1'b0;
            e_unf = 1'b0;
        end else begin
            e_ovf = 1'b0;
            e_unf = 1'b0;
            if (flush) q.delete();
            else if (push && pop && q.size() > 0) q[q.size()-1] = PCPlus4;
            else if (push) begin
                q.push_back(PCPlus4);
                if (q.size() > DEPTH) begin
                    void'(q.pop_front());
                    e_ovf = 1'b1;
                end
            end else if (pop) begin
                if (q.size() == 0) e_unf = 1'b1;
                else void'(q.pop_back());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("m_addr",  RetAddr, q.size() > 0 ? q[q.size()-1] : 32'h0);
            chk("m_count", 32'(Count), 32'(q.size()));
            chk("m_valid", 32'(RetValid), 32'(q.size() > 0));
            chk("m_ovf",   32'(Overflow), 32'(e_ovf));
            chk("m_unf",   32'(Underflow), 32'(e_unf));
        end
    end

    task automatic step(input bit pu, input bit po, input bit fl, input logic [AW-1:0] a);
        push = pu; pop = po; flush = fl; PCPlus4 = a;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_addr",  RetAddr, 32'h0);
        chk("rst_count", 32'(Count), 32'h0);
        chk("rst_valid", 32'(RetValid), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk_en = 1'b1;

        step(1, 0, 0, 32'h104); step(1, 0, 0, 32'h208); step(1, 0, 0, 32'h30C);
        chk("p3_addr",  RetAddr, 32'h30C);
        chk("p3_count", 32'(Count), 32'd3);
        step(0, 1, 0, 0); chk("pop1_addr", RetAddr, 32'h208);
        step(0, 1, 0, 0); chk("pop2_addr", RetAddr, 32'h104);
        chk("pop2_valid", 32'(RetValid), 32'h1);
        step(0, 1, 0, 0); chk("pop3_addr", RetAddr, 32'h0);
        chk("pop3_valid", 32'(RetValid), 32'h0);

        for (int k = 0; k < 9; k++) begin
            step(1, 0, 0, 32'h1000 + 32'(4 * k));
            chk("ovf_pulse", 32'(Overflow), 32'(k == 8));
        end
        chk("ovf_count", 32'(Count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_pop_addr", RetAddr, 32'h1020 - 32'(4 * i));
            step(0, 1, 0, 0);
            chk("ovf_clear", 32'(Overflow), 32'h0);
        end
        chk("drain_addr", RetAddr, 32'h0);
        step(0, 1, 0, 0);
        chk("unf_pulse", 32'(Underflow), 32'h1);
        chk("unf_addr", RetAddr, 32'h0);
        step(0, 0, 0, 0);
        chk("unf_clear", 32'(Underflow), 32'h0);

        step(1, 0, 0, 32'h40);
        step(1, 1, 0, 32'h80);
        chk("swap_count", 32'(Count), 32'd1);
        chk("swap_addr", RetAddr, 32'h80);
        step(0, 1, 0, 0);
        step(1, 1, 0, 32'h90);
        chk("swap0_count", 32'(Count), 32'd1);
        chk("swap0_addr", RetAddr, 32'h90);
        chk("swap0_unf", 32'(Underflow), 32'h0);

        step(1, 0, 0, 32'h10); step(1, 0, 0, 32'h20);
        step(1, 0, 1, 32'h30);
        chk("fl_count", 32'(Count), 32'h0);
        chk("fl_valid", 32'(RetValid), 32'h0);
        chk("fl_addr", RetAddr, 32'h0);
        step(1, 0, 0, 32'h50);
        chk("fl_push_addr", RetAddr, 32'h50);
        chk("fl_push_count", 32'(Count), 32'd1);

        step(1, 0, 0, 32'hAA0); step(1, 0, 0, 32'hBB0);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(RetValid), 32'h0);
        chk("arst_count", 32'(Count), 32'h0);
        chk("arst_addr", RetAddr, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(0, 1, 0, 0);
        chk("arst_unf", 32'(Underflow), 32'h1);

        for (int c = 0; c < 10000; c++) begin
            int r, pw;
            pw = ((c / 500) % 2 == 0) ? 70 : 35;
            r = $urandom_range(0, 99);
            step(r < pw, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 2, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
